plic_claim_complete: RTL and testbench
======================================

// Module: plic_claim_complete
// PURPOSE
//   Hart-side claim/complete unit of the PLIC. Consumes per-source interrupt_masks and
//   priorities from the enable/threshold register block, runs source gateways, keeps
//   pending/in-service state, and arbitrates sequentially for the best eligible source.
//   Serves the claim/complete word on the PLIC register bus and drives the hart's external IRQ.
// PARAMETERS
//   N_interrupts  32  number of source IDs; ID 0 is reserved ("no interrupt"), sources 1..N-1
// PORTS
//   clk                      input   1        system clock
//   n_rst                    input   1        reset, synchronous, active-low
//   interrupt_requests       input   N        raw source lines, bit n = source ID n (bit 0 ignored)
//   interrupt_priority_regs  input   N*32     priority of ID n at [n*32+:32]
//   interrupt_masks          input   N        1 = source masked (disabled or priority <= threshold)
//   claim_complete_addr      input   32       bus address of claim/complete word
//   addr                     input   32       bus address
//   wen                      input   1        bus write strobe (complete)
//   ren                      input   1        bus read strobe (claim)
//   wdata                    input   32       bus write data (completed ID)
//   rdata                    output  32       bus read data (claimed ID, else 0)
//   addr_valid               output  1        addr == claim_complete_addr
//   interrupt_pending        output  N        pending bits, registered
//   external_irq             output  1        to hart: registered best_id != 0
// BEHAVIOUR
//   Reset (n_rst==0 at posedge clk): pending=0, in_service=0, best_id=0, external_irq=0,
//     scan_idx=1, cand_id=0, cand_prio=0, gateway history regs=0. rdata=0 when not claiming.
//   Gateway (per ID n>=1): pending[n] set next cycle on trigger when !in_service[n]; trigger
//     is macro-selected (CONFIGURATION). Trigger seen while in_service[n]=1 is dropped.
//   Arbiter FSM, states SCAN/LOAD:
//     SCAN: each cycle examine scan_idx; eligible = pending & ~mask; if eligible and
//       prio > cand_prio (strict, unsigned 32-bit) capture cand_id/cand_prio. Ties: lower ID wins.
//       scan_idx == N-1 -> LOAD.
//     LOAD: best_id <= cand_id; external_irq <= (cand_id!=0); clear cand; scan_idx<=1; -> SCAN.
//     Full pass = N cycles (N-1 SCAN + 1 LOAD); best_id/external_irq lag sources by <= 2N cycles.
//   Claim: addr_valid & ren. rdata = best_id if best_id still eligible, else 0 (same cycle,
//     combinational). If returned ID != 0: next cycle pending[id]=0, in_service[id]=1,
//     best_id=0, external_irq=0, FSM restarts at SCAN idx 1 with cleared candidate.
//   Complete: addr_valid & wen. If wdata < N, wdata != 0 and in_service[wdata]: clear it
//     next cycle; otherwise ignored, no error.
//   Simultaneous: claim and complete same cycle -> both applied. Trigger on ID being claimed
//     that cycle -> dropped. Trigger on ID being completed that cycle -> dropped (in_service
//     sampled before update). wen & ren same cycle on valid addr -> both applied.
//   Mask change mid-scan: affects only IDs not yet scanned; stale best_id protected by claim check.
//   addr_valid=0: rdata=0, no state change from bus. Reset mid-scan: immediate return to reset state.
// CONFIGURATION
//   PLIC_EDGE_GATEWAY_EN defined: trigger = rising edge of interrupt_requests[n]
//     (registered history, req & ~req_q); a pulse of one cycle is captured.
//   Undefined: level gateway; trigger = interrupt_requests[n]==1; no history regs; a
//     level still high after complete re-pends on the next cycle.
// TESTING
//   1. Reset, N=32, req[5]=1, prio5=3, mask=0 -> within 64 cycles external_irq=1; claim rdata=5;
//      next cycle pending[5]=0, external_irq=0.
//   2. req[3],req[9] pending, prio3=2, prio9=7 -> claim returns 9; then prio equal (4,4) -> returns 3.
//   3. ID 5 in service, raise/retrigger req[5] -> pending[5] stays 0; write complete 5 -> level
//      build: pending[5]=1 next cycle; edge build: stays 0 until new rising edge.
//   4. best_id=7 loaded, then mask[7]=1 before claim -> claim rdata=0, pending[7] unchanged.
//   5. Complete with wdata=0, 40, or non-in-service ID -> no state change; read non-claim addr -> rdata=0, addr_valid=0.
//   6. Assert n_rst=0 mid-scan with pending/in_service set -> all cleared next posedge, external_irq=0.

Source files
------------

// File: rtl/plic_claim_complete.sv
// -----------------------------------------------------------------------------
// plic_claim_complete
//   Hart-side claim/complete unit of a PLIC. Per-source gateways feed a pending
//   vector. A sequential arbiter walks IDs 1..N-1, one per cycle, and then loads
//   the best candidate into best_id / external_irq.
//   The claim/complete word sits at claim_complete_addr on the register bus.
//   A read claims the best source and a write completes a source.
//
//   Build option:
//     PLIC_EDGE_GATEWAY_EN  defined   -> edge gateways (rising edge of request,
//                                        one-cycle pulses are captured)
//                           undefined -> level gateways (request high re-pends
//                                        once the source leaves service)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module plic_claim_complete #(
    parameter int N_interrupts = 32
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [N_interrupts-1:0]      interrupt_requests,
    input  logic [N_interrupts*32-1:0]   interrupt_priority_regs,
    input  logic [N_interrupts-1:0]      interrupt_masks,
    input  logic [31:0]                  claim_complete_addr,
    input  logic [31:0]                  addr,
    input  logic                         wen,
    input  logic                         ren,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata,
    output logic                         addr_valid,
    output logic [N_interrupts-1:0]      interrupt_pending,
    output logic                         external_irq
);

    localparam int              ID_W     = $clog2(N_interrupts);
    localparam logic [ID_W-1:0] FIRST_ID = ID_W'(1);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_interrupts - 1);

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_LOAD = 1'b1
    } arb_state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [N_interrupts-1:0] pending_q,    pending_d;
    logic [N_interrupts-1:0] in_service_q, in_service_d;
    logic [ID_W-1:0]         best_id_q,    best_id_d;
    logic                    external_irq_q, external_irq_d;
    logic [ID_W-1:0]         scan_idx_q,   scan_idx_d;
    logic [ID_W-1:0]         cand_id_q,    cand_id_d;
    logic [31:0]             cand_prio_q,  cand_prio_d;
    arb_state_t              state_q,      state_d;

    // Per-source gateway triggers (bit 0 is the reserved "no interrupt" ID).
    logic [N_interrupts-1:0] trigger;

    // Bus decode and claim/complete qualification.
    logic            claim_req;
    logic            complete_req;
    logic            best_eligible;
    logic            claim_fire;
    logic            complete_in_range;
    logic [ID_W-1:0] complete_id;
    logic            complete_fire;

    // Arbiter view of the ID under examination this cycle.
    logic [31:0]     scan_prio;
    logic            scan_eligible;

    // Request line of the reserved ID never reaches a gateway.
    logic            unused_req0;
    assign unused_req0 = interrupt_requests[0];

    // ---------------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------------
    assign addr_valid   = (addr == claim_complete_addr);
    assign claim_req    = addr_valid & ren;
    assign complete_req = addr_valid & wen;

    // best_id may be stale (mask or pending changed since the last load), so
    // a claim only succeeds if that ID is still pending and unmasked.
    assign best_eligible = (best_id_q != '0)
                         && pending_q[best_id_q]
                         && !interrupt_masks[best_id_q];
    assign claim_fire    = claim_req & best_eligible;
    assign rdata         = claim_fire ? 32'(best_id_q) : 32'd0;

    // Out-of-range, zero and not-in-service completions are silently dropped.
    assign complete_in_range = (wdata != 32'd0) && (wdata < 32'(N_interrupts));
    assign complete_id       = wdata[ID_W-1:0];
    assign complete_fire     = complete_req & complete_in_range
                             & in_service_q[complete_id];

    // ---------------------------------------------------------------------
    // Gateways
    // ---------------------------------------------------------------------
    assign trigger[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < N_interrupts; gi++) begin : g_gateway
`ifdef PLIC_EDGE_GATEWAY_EN
            logic req_hist_q;
            logic req_hist_d;

            assign req_hist_d   = interrupt_requests[gi];
            assign trigger[gi]  = interrupt_requests[gi] & ~req_hist_q;

            // Request history for rising-edge detection.
            always_ff @(posedge clk) begin
                if (!n_rst) begin
                    req_hist_q <= 1'b0;
                end else begin
                    req_hist_q <= req_hist_d;
                end
            end
`else
            assign trigger[gi]  = interrupt_requests[gi];
`endif
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Pending / in-service next state
    // ---------------------------------------------------------------------
    // Triggers are gated by the in-service bit as it was before this cycle's
    // claim/complete, so a trigger on an ID being completed is dropped. The
    // claim clear comes last so a trigger on the ID being claimed is dropped.
    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        for (int n = 1; n < N_interrupts; n++) begin
            if (trigger[n] && !in_service_q[n]) begin
                pending_d[n] = 1'b1;
            end
        end
        if (complete_fire) begin
            in_service_d[complete_id] = 1'b0;
        end
        if (claim_fire) begin
            pending_d[best_id_q]    = 1'b0;
            in_service_d[best_id_q] = 1'b1;
        end
        pending_d[0]    = 1'b0;
        in_service_d[0] = 1'b0;
    end

    // ---------------------------------------------------------------------
    // Sequential arbiter
    // ---------------------------------------------------------------------
    assign scan_prio     = interrupt_priority_regs[{scan_idx_q, 5'd0} +: 32];
    assign scan_eligible = pending_q[scan_idx_q] & ~interrupt_masks[scan_idx_q];

    // SCAN walks one ID per cycle keeping the strictly-higher priority
    // candidate. IDs are walked in ascending order, so on a tie the lower ID
    // wins. LOAD publishes the candidate. A successful claim restarts the pass
    // so the claimed ID cannot be re-published from a stale candidate.
    always_comb begin
        state_d        = state_q;
        scan_idx_d     = scan_idx_q;
        cand_id_d      = cand_id_q;
        cand_prio_d    = cand_prio_q;
        best_id_d      = best_id_q;
        external_irq_d = external_irq_q;

        case (state_q)
            ST_SCAN: begin
                if (scan_eligible && (scan_prio > cand_prio_q)) begin
                    cand_id_d   = scan_idx_q;
                    cand_prio_d = scan_prio;
                end
                if (scan_idx_q == LAST_ID) begin
                    state_d = ST_LOAD;
                end else begin
                    scan_idx_d = scan_idx_q + FIRST_ID;
                end
            end
            ST_LOAD: begin
                best_id_d      = cand_id_q;
                external_irq_d = (cand_id_q != '0);
                cand_id_d      = '0;
                cand_prio_d    = '0;
                scan_idx_d     = FIRST_ID;
                state_d        = ST_SCAN;
            end
            default: begin
                state_d    = ST_SCAN;
                scan_idx_d = FIRST_ID;
            end
        endcase

        if (claim_fire) begin
            best_id_d      = '0;
            external_irq_d = 1'b0;
            cand_id_d      = '0;
            cand_prio_d    = '0;
            scan_idx_d     = FIRST_ID;
            state_d        = ST_SCAN;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // All unit state, including the arbiter FSM and its registered outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pending_q      <= '0;
            in_service_q   <= '0;
            best_id_q      <= '0;
            external_irq_q <= 1'b0;
            scan_idx_q     <= FIRST_ID;
            cand_id_q      <= '0;
            cand_prio_q    <= '0;
            state_q        <= ST_SCAN;
        end else begin
            pending_q      <= pending_d;
            in_service_q   <= in_service_d;
            best_id_q      <= best_id_d;
            external_irq_q <= external_irq_d;
            scan_idx_q     <= scan_idx_d;
            cand_id_q      <= cand_id_d;
            cand_prio_q    <= cand_prio_d;
            state_q        <= state_d;
        end
    end

    assign interrupt_pending = pending_q;
    assign external_irq      = external_irq_q;

endmodule

// File: tb/tb_plic_claim_complete.sv
// -----------------------------------------------------------------------------
// tb_plic_claim_complete
//   Scoreboard bench: the driver pushes expected values tagged with a probe
//   number, and a monitor pops and compares them on the falling edge while
//   the probe is raised. The reference model is a set-level view (pending,
//   in-service, masks, priorities) with the best source computed as
//   "highest priority, then lowest ID".
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_plic_claim_complete;

    localparam int          N       = 32;
    localparam logic [31:0] CC_ADDR = 32'h0020_0004;
    localparam int          SEL_RDATA = 0;
    localparam int          SEL_AV    = 1;
    localparam int          SEL_PEND  = 2;
    localparam int          SEL_IRQ   = 3;

    logic              clk = 1'b0;
    logic              n_rst;
    logic [N-1:0]      req;
    logic [N*32-1:0]   prio_bus;
    logic [N-1:0]      mask;
    logic [31:0]       addr, wdata, rdata;
    logic              wen, ren, addr_valid, irq;
    logic [N-1:0]      pend;

    always #5 clk = ~clk;

    plic_claim_complete #(.N_interrupts(N)) dut (
        .clk                     (clk),
        .n_rst                   (n_rst),
        .interrupt_requests      (req),
        .interrupt_priority_regs (prio_bus),
        .interrupt_masks         (mask),
        .claim_complete_addr     (CC_ADDR),
        .addr                    (addr),
        .wen                     (wen),
        .ren                     (ren),
        .wdata                   (wdata),
        .rdata                   (rdata),
        .addr_valid              (addr_valid),
        .interrupt_pending       (pend),
        .external_irq            (irq)
    );

    // Reference model state
    bit [N-1:0] m_pend, m_insvc, m_mask;
    bit [31:0]  m_prio [N];

    assign mask = m_mask;
    always_comb begin
        prio_bus = '0;
        for (int n = 0; n < N; n++) prio_bus[n*32 +: 32] = m_prio[n];
    end

    // Scoreboard
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
        int          tag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] act;
    int          total = 0;
    int          bad   = 0;
    logic        probe = 1'b0;
    int          probe_tag = 0;
    int          tag_ctr = 0;

    always @(negedge clk) begin
        if (probe) begin
            while (exp_q.size() > 0 && exp_q[0].tag == probe_tag) begin
                cur = exp_q.pop_front();
                case (cur.sel)
                    SEL_RDATA: act = rdata;
                    SEL_AV:    act = {31'd0, addr_valid};
                    SEL_PEND:  act = pend;
                    default:   act = {31'd0, irq};
                endcase
                total++;
                if (act !== cur.val) begin
                    bad++;
                    $display("FAIL %s: got %h, want %h (t=%0t)", cur.name, act, cur.val, $time);
                end else begin
                    $display("ok   %s: %h", cur.name, act);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(string nm, int sel, logic [31:0] v);
        exp_t e;
        e.name = nm; e.sel = sel; e.val = v; e.tag = tag_ctr;
        exp_q.push_back(e);
    endtask

    task automatic probe_now();
        probe     = 1'b1;
        probe_tag = tag_ctr;
        @(negedge clk);
        #1;
        probe = 1'b0;
        tag_ctr++;
    endtask

    task automatic check_pend(string nm);
        expect_val(nm, SEL_PEND, m_pend);
        probe_now();
        tick();
    endtask

    task automatic check_irq(string nm, bit v);
        expect_val(nm, SEL_IRQ, {31'd0, v});
        probe_now();
        tick();
    endtask

    function automatic int model_best();
        bit [31:0] top = 0;
        for (int n = 1; n < N; n++)
            if (m_pend[n] && !m_mask[n] && m_prio[n] > top) top = m_prio[n];
        if (top == 0) return 0;
        for (int n = 1; n < N; n++)
            if (m_pend[n] && !m_mask[n] && m_prio[n] == top) return n;
        return 0;
    endfunction

    task automatic pulse(int id);
        req[id] = 1'b1;
        tick();
        req[id] = 1'b0;
        if (!m_insvc[id]) m_pend[id] = 1'b1;
    endtask

    task automatic complete_at(logic [31:0] a, int v);
        addr = a; wdata = 32'(v); wen = 1'b1;
        tick();
        wen = 1'b0; addr = 32'd0;
        if (a == CC_ADDR && v > 0 && v < N && m_insvc[v]) m_insvc[v] = 1'b0;
    endtask

    task automatic do_claim(string nm, int exp_id);
        addr = CC_ADDR; ren = 1'b1;
        expect_val(nm, SEL_RDATA, 32'(exp_id));
        expect_val({nm, "_av"}, SEL_AV, 32'd1);
        probe_now();
        tick();
        ren = 1'b0; addr = 32'd0;
        if (exp_id != 0) begin
            m_pend[exp_id]  = 1'b0;
            m_insvc[exp_id] = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (2*N + 4) tick();
    endtask

    task automatic do_reset();
        n_rst = 1'b0; req = '0; wen = 1'b0; ren = 1'b0; addr = 32'd0;
        m_mask = '0;
        for (int n = 0; n < N; n++) m_prio[n] = 0;
        tick();
        n_rst = 1'b1;
        m_pend = '0; m_insvc = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v;
        int w;
        int op;
        int id;

        n_rst = 1'b0; req = '0; addr = 32'd0; wdata = 32'd0; wen = 1'b0; ren = 1'b0;
        m_mask = '0; m_pend = '0; m_insvc = '0;
        for (int n = 0; n < N; n++) m_prio[n] = 0;
        tick(); tick();
        n_rst = 1'b1;

        // Reset state; bus idle on the claim address gives rdata=0.
        addr = CC_ADDR;
        expect_val("rst_pend", SEL_PEND, 32'd0);
        expect_val("rst_irq", SEL_IRQ, 32'd0);
        expect_val("rst_rdata_noread", SEL_RDATA, 32'd0);
        expect_val("rst_av", SEL_AV, 32'd1);
        probe_now();
        tick();
        addr = 32'd0;

        // 1: single source reaches the hart and is claimed.
        do_reset();
        m_prio[5] = 3;
        pulse(5);
        w = 0;
        while (!irq && w < 64) begin tick(); w++; end
        check_irq("t1_irq", 1'b1);
        do_claim("t1_claim", 5);
        check_pend("t1_pend");
        check_irq("t1_irq_clr", 1'b0);

        // 2: higher priority wins, then equal priority -> lower ID.
        do_reset();
        m_prio[3] = 2; m_prio[9] = 7;
        pulse(3); pulse(9);
        settle();
        check_irq("t2_irq", 1'b1);
        do_claim("t2_claim_hi", 9);
        complete_at(CC_ADDR, 9);
        m_prio[3] = 4; m_prio[9] = 4;
        pulse(9);
        settle();
        do_claim("t2_claim_tie", 3);
        check_pend("t2_pend");

        // 3: retrigger while in service, then complete.
        do_reset();
        m_prio[5] = 3;
        pulse(5);
        settle();
        do_claim("t3_claim", 5);
        req[5] = 1'b1;
        repeat (4) tick();
        check_pend("t3_held");
        complete_at(CC_ADDR, 5);
        tick();
`ifndef PLIC_EDGE_GATEWAY_EN
        m_pend[5] = 1'b1;
`endif
        check_pend("t3_after_cpl");
        req[5] = 1'b0;
        tick();
`ifdef PLIC_EDGE_GATEWAY_EN
        pulse(5);
`endif
        check_pend("t3_repend");

        // 4: stale best_id protected by the eligibility check at claim.
        do_reset();
        m_prio[7] = 5;
        pulse(7);
        settle();
        check_irq("t4_irq", 1'b1);
        m_mask[7] = 1'b1;
        tick();
        do_claim("t4_claim_masked", 0);
        check_pend("t4_pend");

        // 5: ignored completions and non-claim address.
        do_reset();
        m_prio[4] = 6; m_prio[6] = 2;
        pulse(4);
        settle();
        do_claim("t5_claim4", 4);
        pulse(6);
        complete_at(CC_ADDR, 0);
        complete_at(CC_ADDR, 40);
        complete_at(CC_ADDR, 6);
        complete_at(CC_ADDR + 32'd4, 4);
        check_pend("t5_pend");
        settle();
        addr = CC_ADDR + 32'd4; ren = 1'b1;
        expect_val("t5_rd_other", SEL_RDATA, 32'd0);
        expect_val("t5_av_other", SEL_AV, 32'd0);
        probe_now();
        tick();
        ren = 1'b0; addr = 32'd0;
        pulse(4);
        check_pend("t5_insvc_kept");
        settle();
        do_claim("t5_claim6", 6);

        // 6: reset mid-scan clears everything.
        do_reset();
        m_prio[2] = 1; m_prio[8] = 3;
        pulse(2); pulse(8);
        settle();
        do_claim("t6_claim", 8);
        repeat (10) tick();
        n_rst = 1'b0;
        tick();
        m_pend = '0; m_insvc = '0;
        check_pend("t6_rst_pend");
        check_irq("t6_rst_irq", 1'b0);
        n_rst = 1'b1;
        pulse(8);
        check_pend("t6_insvc_clr");

        // Randomized traffic against the model.
        do_reset();
        for (int n = 1; n < N; n++) m_prio[n] = $urandom_range(0, 7);
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                id = $urandom_range(1, N-1);
                pulse(id);
                check_pend("rnd_pulse");
            end else if (op <= 5) begin
                v = $urandom_range(0, 45);
                for (int k = 1; k < N; k++)
                    if (m_insvc[k] && $urandom_range(0, 2) == 0) v = k;
                complete_at(CC_ADDR, v);
                check_pend("rnd_cpl");
            end else if (op == 6) begin
                id = $urandom_range(1, N-1);
                m_mask[id] = ($urandom_range(0, 3) == 0);
                tick();
            end else if (op == 7) begin
                id = $urandom_range(1, N-1);
                m_prio[id] = $urandom_range(0, 7);
                tick();
            end else begin
                settle();
                v = model_best();
                check_irq("rnd_irq", v != 0);
                do_claim("rnd_claim", v);
                check_pend("rnd_claim_pend");
                check_irq("rnd_irq_clr", 1'b0);
            end
        end

        repeat (2) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
